// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life board row movers (SIPO window / PISO serializer).
// Holds the row geometry and the two-state block controller encoding.
package gol_pkg;

    localparam int ROW_W        = 20;
    localparam int ROWS_PER_BLK = 3;

    // Width of a word index; a 1-word block still needs one bit to carry idx.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_w(ROWS_PER_BLK);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } blk_state_e;

endpackage

// File: rtl/super_piso.sv
// Parallel-in / serial-out block serializer with valid/ack handshake, word 0 first.
// Optional synchronous frame abort input enabled by defining SUPER_PISO_ABORT_EN.
module super_piso
    import gol_pkg::*;
#(
    parameter int  DW = ROW_W,
    parameter int  NW = ROWS_PER_BLK,
    localparam int IW = idx_w(NW)
) (
    input  logic             clk_50MHz_i,
    input  logic             rst_async_la_i,
`ifdef SUPER_PISO_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             load_i,
    input  logic [DW*NW-1:0] D_i,
    output logic             ready_o,
    output logic [DW-1:0]    Q_o,
    output logic             valid_o,
    input  logic             ack_i,
    output logic [IW-1:0]    idx_o,
    output logic             last_o
);

    blk_state_e         r_state;
    logic [DW*NW-1:0]   r_shift;
    logic [IW-1:0]      r_idx;

    logic               w_abort;
    logic               w_xfer;
    logic               w_load;
    logic               w_last;
    logic [DW*NW-1:0]   w_shifted;

`ifdef SUPER_PISO_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    assign valid_o   = (r_state == SEND);
    assign w_last    = valid_o && (r_idx == IW'(NW - 1));
    assign w_xfer    = valid_o && ack_i;
    // Ready during the final transfer so the next block follows with no bubble.
    assign ready_o   = (r_state == IDLE) || (w_xfer && w_last);
    assign w_load    = load_i && ready_o && !w_abort;
    assign w_shifted = {{DW{1'b0}}, r_shift[DW*NW-1:DW]};

    assign Q_o    = r_shift[DW-1:0];
    assign idx_o  = r_idx;
    assign last_o = w_last;

    always_ff @(posedge clk_50MHz_i or negedge rst_async_la_i) begin
        if (!rst_async_la_i) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_abort) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_load) begin
            r_state <= SEND;
            r_shift <= D_i;
            r_idx   <= '0;
        end else if (w_xfer) begin
            // Zero fill leaves Q_o=0 once the last word has been shifted out.
            r_shift <= w_shifted;
            if (w_last) begin
                r_state <= IDLE;
                r_idx   <= '0;
            end else begin
                r_idx   <= r_idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_super_piso.sv
// Bench for super_piso: stimulus pushes expected words to a queue, a monitor checks each transfer.
module tb_super_piso;
    import gol_pkg::*;

    localparam int DW = ROW_W;
    localparam int NW = ROWS_PER_BLK;
    localparam int IW = IDX_W;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load = 1'b0;
    logic [DW*NW-1:0] din = '0;
    logic             ack = 1'b0;
    logic             ready, valid, last;
    logic [DW-1:0]    q;
    logic [IW-1:0]    idx;
`ifdef SUPER_PISO_ABORT_EN
    logic             abort = 1'b0;
`endif

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    super_piso dut (
        .clk_50MHz_i    (clk),
        .rst_async_la_i (rst_n),
`ifdef SUPER_PISO_ABORT_EN
        .abort_i        (abort),
`endif
        .load_i         (load),
        .D_i            (din),
        .ready_o        (ready),
        .Q_o            (q),
        .valid_o        (valid),
        .ack_i          (ack),
        .idx_o          (idx),
        .last_o         (last)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_block(input logic [DW*NW-1:0] d);
        for (int k = 0; k < NW; k++)
            sb.push_back('{q: d[DW*k +: DW], idx: IW'(k), last: (k == NW - 1)});
    endtask

    // Issue a load that the DUT accepts at the next edge.
    task automatic issue_load(input logic [DW*NW-1:0] d);
        din  = d;
        load = 1'b1;
        push_block(d);
        tick();
        load = 1'b0;
    endtask

    // Monitor: every transfer must match the next expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid && ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_xfer", {8'd0, q, idx, last}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("xfer_word", {8'd0, q, idx, last}, {8'd0, e.q, e.idx, e.last});
                end
            end
        end
    end

    localparam logic [DW*NW-1:0] BLK_A = 60'hABCDE_12345_0F0F0;
    localparam logic [DW*NW-1:0] BLK_B = 60'h11111_22222_33333;

    initial begin
        // Reset values while held in reset.
        #5;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_idx", 32'(idx), 32'h0);
        chk("rst_last", 32'(last), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic block with ack held high.
        ack = 1'b1;
        issue_load(BLK_A);
        chk("t1_w0_q", 32'(q), 32'h0F0F0);
        chk("t1_w0_ready", 32'(ready), 32'h0);
        tick();
        chk("t1_w1_idx", 32'(idx), 32'h1);
        tick();
        chk("t1_w2_last", 32'(last), 32'h1);
        tick();
        chk("t1_end_valid", 32'(valid), 32'h0);
        chk("t1_end_ready", 32'(ready), 32'h1);
        chk("t1_end_q", 32'(q), 32'h0);
        chk("t1_end_idx", 32'(idx), 32'h0);
        tick();

        // Stall on word 1 for four cycles.
        issue_load(BLK_A);
        tick();
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_q", 32'(q), 32'h12345);
            chk("t2_stall_idx", 32'(idx), 32'h1);
            chk("t2_stall_valid", 32'(valid), 32'h1);
            tick();
        end
        ack = 1'b1;
        tick();
        tick();
        chk("t2_end_valid", 32'(valid), 32'h0);
        tick();

        // Back-to-back blocks: six contiguous valid cycles.
        issue_load(BLK_A);
        chk("t3_v1", 32'(valid), 32'h1);
        tick();
        chk("t3_v2", 32'(valid), 32'h1);
        tick();
        chk("t3_last_ready", 32'(ready), 32'h1);
        issue_load(BLK_B);
        chk("t3_b0_q", 32'(q), 32'h33333);
        chk("t3_b0_idx", 32'(idx), 32'h0);
        chk("t3_v4", 32'(valid), 32'h1);
        tick();
        chk("t3_v5", 32'(valid), 32'h1);
        tick();
        chk("t3_v6", 32'(valid), 32'h1);
        tick();
        chk("t3_end_valid", 32'(valid), 32'h0);
        tick();

        // Load pulsed mid-block is ignored.
        issue_load(BLK_A);
        tick();
        chk("t4_busy_ready", 32'(ready), 32'h0);
        din  = BLK_B;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("t4_w2_q", 32'(q), 32'hABCDE);
        tick();
        chk("t4_end_valid", 32'(valid), 32'h0);
        tick();

        // Asynchronous reset mid word 1 drops the frame at once.
        issue_load(BLK_A);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_q", 32'(q), 32'h0);
        chk("t5_rst_valid", 32'(valid), 32'h0);
        chk("t5_rst_idx", 32'(idx), 32'h0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        issue_load(BLK_B);
        tick();
        tick();
        tick();
        chk("t5_after_valid", 32'(valid), 32'h0);

`ifdef SUPER_PISO_ABORT_EN
        // Abort with a simultaneous load at idx 1: nothing new is loaded.
        issue_load(BLK_A);
        tick();
        ack   = 1'b0;
        abort = 1'b1;
        din   = BLK_B;
        load  = 1'b1;
        tick();
        abort = 1'b0;
        load  = 1'b0;
        ack   = 1'b1;
        sb.delete();
        chk("t6_abort_valid", 32'(valid), 32'h0);
        chk("t6_abort_idx", 32'(idx), 32'h0);
        chk("t6_abort_q", 32'(q), 32'h0);
        tick();
        chk("t6_still_idle", 32'(valid), 32'h0);
`endif

        tick();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
